gsim_b_feeder: RTL

- Transmit side of the GSIM b-vector input interface.
- A host loads the N right-hand-side coefficients b[0..N-1] through a valid/ready write port.
- On `start`, the block drives them to the solver as one burst on `in_en`/`b_in`.
- It then counts the solver's `out_valid` pulses, and signals `done` once all N x results have been returned, so the next vector can be sent.

---
 rtl/gsim_feed_pkg.sv | 23 ++
 rtl/gsim_feed_buf.sv | 33 +++
 rtl/gsim_b_feeder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/gsim_feed_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gsim_feed_pkg
//  Purpose  : Shared types and default constants for the GSIM b-vector feeder.
//  Revision : 1.0 - initial release
// ============================================================================
package gsim_feed_pkg;

    // Feeder controller states.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,  // host is writing the vector
        ST_FULL = 2'd1,  // vector complete, waiting for start
        ST_SEND = 2'd2,  // burst to the solver in progress
        ST_WAIT = 2'd3   // burst sent, collecting solver results
    } feed_state_e;

    localparam int GSIM_N_DEFAULT  = 16;
    localparam int GSIM_DW_DEFAULT = 16;
    // Index/result counters must be able to hold the value N itself.
    localparam int GSIM_CW_DEFAULT = $clog2(GSIM_N_DEFAULT) + 1;

endpackage : gsim_feed_pkg
`default_nettype wire

// File: rtl/gsim_feed_buf.sv
`default_nettype none
// ============================================================================
//  Module   : gsim_feed_buf
//  Purpose  : N x DW register file holding the b vector. One write port,
//             one combinational read port, data storage is not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module gsim_feed_buf #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [N];

    // Store one coefficient per accepted host write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : gsim_feed_buf
`default_nettype wire

// File: rtl/gsim_b_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : gsim_b_feeder
//  Purpose  : Transmit side of the GSIM b-vector interface. Buffers N host
//             words, sends them to the solver as one burst on start, then
//             counts returned results and pulses done after N of them.
//  Options  : GSIM_FEED_REPLAY_EN - keep the vector after done (return to
//             FULL) and add a reload input that forces a fresh load.
//  Revision : 1.0 - initial release
// ============================================================================
module gsim_b_feeder
    import gsim_feed_pkg::*;
#(
    parameter int N  = GSIM_N_DEFAULT,
    parameter int DW = GSIM_DW_DEFAULT,
    parameter int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          start,
    output logic          in_en,
    output logic [DW-1:0] b_in,
    input  logic          out_valid,
`ifdef GSIM_FEED_REPLAY_EN
    input  logic          reload,
`endif
    output logic          busy,
    output logic          done
);

    localparam int            AW        = CW - 1;
    localparam logic [CW-1:0] N_CNT     = CW'(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

`ifdef GSIM_FEED_REPLAY_EN
    // Replay keeps the buffer, so a finished transaction waits for a new start.
    localparam feed_state_e ST_AFTER_DONE = ST_FULL;
`else
    localparam feed_state_e ST_AFTER_DONE = ST_LOAD;
`endif

    feed_state_e   state_q, state_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;
    logic          wr_ready_q, wr_ready_d;
    logic          in_en_q, in_en_d;
    logic [DW-1:0] b_in_q, b_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          wr_fire;
    logic          cnt_en;
    logic [CW-1:0] res_cnt_inc;
    logic [DW-1:0] rd_data;

    assign wr_fire     = (state_q == ST_LOAD) && wr_valid && wr_ready_q;
    assign cnt_en      = out_valid && ((state_q == ST_SEND) || (state_q == ST_WAIT));
    // Result count saturates at N.
    assign res_cnt_inc = (cnt_en && (res_cnt_q != N_CNT)) ? res_cnt_q + 1'b1 : res_cnt_q;

    gsim_feed_buf #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_idx_q),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_idx_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    // Next-state and registered-output logic for the feeder controller.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        res_cnt_d = res_cnt_q;
        in_en_d   = 1'b0;
        b_in_d    = '0;
        done_d    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // start is ignored here: a partial vector is never sent.
                if (wr_fire) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_ADDR) begin
                        state_d  = ST_FULL;
                        wr_idx_d = '0;
                    end
                end
            end
            ST_FULL: begin
                rd_idx_d = '0;
                if (start) begin
                    // rd_idx is 0 here, so rd_data is b[0] for the first beat.
                    state_d   = ST_SEND;
                    in_en_d   = 1'b1;
                    b_in_d    = rd_data;
                    rd_idx_d  = CW'(1);
                    res_cnt_d = '0;
                end
            end
            ST_SEND: begin
                res_cnt_d = res_cnt_inc;
                if (rd_idx_q != N_CNT) begin
                    in_en_d  = 1'b1;
                    b_in_d   = rd_data;
                    rd_idx_d = rd_idx_q + 1'b1;
                end else if (res_cnt_inc == N_CNT) begin
                    // Solver already returned everything: finish without WAIT.
                    done_d    = 1'b1;
                    state_d   = ST_AFTER_DONE;
                    wr_idx_d  = '0;
                    rd_idx_d  = '0;
                    res_cnt_d = '0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                res_cnt_d = res_cnt_inc;
                if (res_cnt_inc == N_CNT) begin
                    done_d    = 1'b1;
                    state_d   = ST_AFTER_DONE;
                    wr_idx_d  = '0;
                    rd_idx_d  = '0;
                    res_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

`ifdef GSIM_FEED_REPLAY_EN
        // reload abandons whatever is in progress and restarts the load.
        if (reload) begin
            state_d   = ST_LOAD;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            res_cnt_d = '0;
            in_en_d   = 1'b0;
            b_in_d    = '0;
            done_d    = 1'b0;
        end
`endif

        // wr_ready trails entry into LOAD by one cycle and drops right after the last write.
        wr_ready_d = (state_q == ST_LOAD) && (state_d == ST_LOAD);
        busy_d     = (state_d == ST_SEND) || (state_d == ST_WAIT);
    end

    // Controller state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            res_cnt_q  <= '0;
            wr_ready_q <= 1'b0;
            in_en_q    <= 1'b0;
            b_in_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            res_cnt_q  <= res_cnt_d;
            wr_ready_q <= wr_ready_d;
            in_en_q    <= in_en_d;
            b_in_q     <= b_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign in_en    = in_en_q;
    assign b_in     = b_in_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : gsim_b_feeder
`default_nettype wire
